quad_encoder: RTL and testbench

Two-axis quadrature pulse generator. It converts signed per-frame mouse or trackball deltas from the HPS/PS2 input path into A/B quadrature waveforms. The waveforms drive the LETA trackball inputs (X1/Y1 … X4/Y4) exactly as a physical Atari trackball would. It is the transmit end of the quadrature link whose receive end is the per-axis quadrature decoder inside LETA.

---
 rtl/quad_encoder_pkg.sv | 46 ++++
 rtl/quad_axis.sv | 69 ++++++
 rtl/quad_encoder.sv | 56 +++++
 tb/tb_quad_encoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_encoder_pkg.sv
// Shared constants and helpers for the two-axis quadrature pulse generator.
// Holds the phase encoding, delta width and saturating arithmetic.
package quad_encoder_pkg;

  localparam int DELTA_W = 9;

  // Phase (A,B) values, listed in the order of a positive walk.
  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b10;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b01;

  // Sum of a and b, clamped symmetrically to +/-(2^(acc_w-1)-1).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int                 acc_w);
    logic signed [31:0] lim;
    logic signed [31:0] sum;
    lim = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
    sum = a + b;
    if (sum > lim)       return lim;
    else if (sum < -lim) return -lim;
    return sum;
  endfunction

  // Negation that maps the most negative delta onto the most positive one.
  function automatic logic signed [DELTA_W-1:0] sat_neg(input logic signed [DELTA_W-1:0] d);
    if (d == {1'b1, {(DELTA_W-1){1'b0}}}) return {1'b0, {(DELTA_W-1){1'b1}}};
    return -d;
  endfunction

  // One quadrature step forward (fwd=1) or backward (fwd=0).
  function automatic logic [1:0] phase_step(input logic [1:0] ph, input logic fwd);
    logic [1:0] nxt;
    nxt = ph;
    case (ph)
      PH0: nxt = fwd ? PH1 : PH3;
      PH1: nxt = fwd ? PH2 : PH0;
      PH2: nxt = fwd ? PH3 : PH1;
      PH3: nxt = fwd ? PH0 : PH2;
      default: nxt = PH0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_axis.sv
// One quadrature axis: signed pending accumulator, step-rate divider and a
// phase register that drives A/B directly.
module quad_axis
  import quad_encoder_pkg::*;
#(
  parameter int STEP_DIV = 64,
  parameter int ACC_W    = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ce,
  input  logic                      strobe,
  input  logic signed [DELTA_W-1:0] delta,
  output logic                      a,
  output logic                      b,
  output logic                      busy
);

  localparam int             DIV_W    = $clog2(STEP_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  logic signed [ACC_W-1:0] pending, pending_next;
  logic [DIV_W-1:0]        div, div_next;
  logic [1:0]              phase, phase_next;
  logic                    take_step;
  logic signed [31:0]      step, pend_ext, delta_ext;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    take_step    = 1'b0;
    step         = '0;
    pend_ext     = 32'(pending);
    delta_ext    = 32'(delta);
    pending_next = pending;
    div_next     = div;
    phase_next   = phase;

    take_step = ce && (pending != '0) && (div == DIV_LAST);
    if (take_step) step = pending[ACC_W-1] ? -32'sd1 : 32'sd1;

    // A coincident strobe and step resolve in a single saturating update.
    if (strobe) pending_next = ACC_W'(sat_add(pend_ext - step, delta_ext, ACC_W));
    else        pending_next = ACC_W'(pend_ext - step);

    if (pending == '0)           div_next = '0;
    else if (ce)                 div_next = (div == DIV_LAST) ? '0 : div + 1'b1;

    if (take_step) phase_next = phase_step(phase, !pending[ACC_W-1]);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
      div     <= '0;
      phase   <= PH0;
      busy    <= 1'b0;
    end else begin
      pending <= pending_next;
      div     <= div_next;
      phase   <= phase_next;
      busy    <= (pending_next != '0);
    end
  end

  assign a = phase[1];
  assign b = phase[0];

endmodule

// File: rtl/quad_encoder.sv
// Two-axis quadrature pulse generator turning signed per-frame deltas into A/B
// waveforms. Define QUAD_ENC_INVERT_Y_EN to negate dy (saturating) before use.
module quad_encoder
  import quad_encoder_pkg::*;
#(
  parameter int STEP_DIV = 64,
  parameter int ACC_W    = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      ce,
  input  logic                      strobe,
  input  logic signed [DELTA_W-1:0] dx,
  input  logic signed [DELTA_W-1:0] dy,
  output logic                      XA,
  output logic                      XB,
  output logic                      YA,
  output logic                      YB,
  output logic                      busy
);

  logic signed [DELTA_W-1:0] dy_eff;
  logic                      busy_x, busy_y;

`ifdef QUAD_ENC_INVERT_Y_EN
  // Screen-down-positive sources count the opposite way on Y.
  assign dy_eff = sat_neg(dy);
`else
  assign dy_eff = dy;
`endif

  quad_axis #(.STEP_DIV(STEP_DIV), .ACC_W(ACC_W)) u_axis_x (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .strobe  (strobe),
    .delta   (dx),
    .a       (XA),
    .b       (XB),
    .busy    (busy_x)
  );

  quad_axis #(.STEP_DIV(STEP_DIV), .ACC_W(ACC_W)) u_axis_y (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .strobe  (strobe),
    .delta   (dy_eff),
    .a       (YA),
    .b       (YB),
    .busy    (busy_y)
  );

  assign busy = busy_x | busy_y;

endmodule

// File: tb/tb_quad_encoder.sv
// Self-checking bench for quad_encoder: directed bursts plus random traffic
// compared against a position-based reference model and a looped-back decoder.
module tb_quad_encoder;

  localparam int STEP_DIV = 4;
  localparam int ACC_W    = 9;
  localparam int LIM      = (1 << (ACC_W - 1)) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ce;
  logic              strobe;
  logic signed [8:0] dx, dy;
  logic              XA, XB, YA, YB, busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending motion, divider count and absolute position per axis.
  int pend[2];
  int dv[2];
  int pos[2];

  // Looped-back decoder state per axis.
  logic [1:0] prev_x, prev_y;
  logic [8:0] dec_x, dec_y;

  quad_encoder #(.STEP_DIV(STEP_DIV), .ACC_W(ACC_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .strobe  (strobe),
    .dx      (dx),
    .dy      (dy),
    .XA      (XA),
    .XB      (XB),
    .YA      (YA),
    .YB      (YB),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ph_of(input int p);
    int m;
    m = ((p % 4) + 4) % 4;
    case (m)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int clamp(input int v);
    if (v > LIM)  return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  function automatic logic model_busy();
    return (pend[0] != 0) || (pend[1] != 0);
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin
      pend[a] = 0;
      dv[a]   = 0;
      pos[a]  = 0;
    end
  endtask

  task automatic model_tick(input bit stb, input bit cev, input int d0, input int d1);
    int d[2];
    int s;
    int nd;
    d[0] = d0;
    d[1] = d1;
`ifdef QUAD_ENC_INVERT_Y_EN
    d[1] = -d[1];
    if (d[1] > 255) d[1] = 255;
`endif
    for (int a = 0; a < 2; a++) begin
      s = 0;
      if (cev && pend[a] != 0 && dv[a] == STEP_DIV - 1) s = (pend[a] > 0) ? 1 : -1;
      nd = (pend[a] == 0) ? 0 : (cev ? (dv[a] + 1) % STEP_DIV : dv[a]);
      if (stb) pend[a] = clamp(pend[a] + d[a] - s);
      else     pend[a] = pend[a] - s;
      pos[a] = pos[a] + s;
      dv[a]  = nd;
    end
  endtask

  task automatic sample_dec();
    logic [1:0] cx, cy;
    cx = {XA, XB};
    cy = {YA, YB};
    if (cx != prev_x) dec_x = (cx[1] ^ prev_x[0]) ? dec_x + 9'd1 : dec_x - 9'd1;
    if (cy != prev_y) dec_y = (cy[1] ^ prev_y[0]) ? dec_y + 9'd1 : dec_y - 9'd1;
    prev_x = cx;
    prev_y = cy;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cycle(input bit stb, input logic signed [8:0] vx,
                       input logic signed [8:0] vy, input bit cev);
    strobe = stb;
    dx     = vx;
    dy     = vy;
    ce     = cev;
    @(posedge clk);
    model_tick(stb, cev, int'(vx), int'(vy));
    #1;
    sample_dec();
    check("x_phase", 32'({XA, XB}), 32'(ph_of(pos[0])));
    check("y_phase", 32'({YA, YB}), 32'(ph_of(pos[1])));
    check("busy",    32'(busy),     32'(model_busy()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 9'sd0, 9'sd0, 1'b1);
  endtask

  logic [8:0] d0;
  logic signed [8:0] ydelta;
  int guard;

  initial begin
    reset_n = 1'b0;
    ce      = 1'b0;
    strobe  = 1'b0;
    dx      = '0;
    dy      = '0;
    model_reset();
    prev_x = 2'b00;
    prev_y = 2'b00;
    dec_x  = '0;
    dec_y  = '0;
    #1;
    check("reset_out", 32'({XA, XB, YA, YB, busy}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset: nothing moves for 1000 cycles.
    idle(1000);
    check("idle_dec_x", 32'(dec_x), 32'd0);

    // Positive X burst of +3.
    cycle(1'b1, 9'sd3, 9'sd0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 9'sd0, 9'sd0, 1'b1);
      if (k == 3)  check("pos_before_first", 32'({XA, XB}), 32'(2'b00));
      if (k == 4)  check("pos_edge4",  32'({XA, XB}), 32'(2'b10));
      if (k == 8)  check("pos_edge8",  32'({XA, XB}), 32'(2'b11));
      if (k == 11) check("pos_busy11", 32'(busy), 32'd1);
      if (k == 12) begin
        check("pos_edge12", 32'({XA, XB}), 32'(2'b01));
        check("pos_busy12", 32'(busy), 32'd0);
      end
    end
    check("pos_dec_count",  32'(dec_x), 32'd3);
    check("pos_dec_output", 32'(dec_x[8:1]), 32'd1);

    // Negative Y burst (a positive dy when Y is inverted).
`ifdef QUAD_ENC_INVERT_Y_EN
    ydelta = 9'sd2;
`else
    ydelta = -9'sd2;
`endif
    cycle(1'b1, 9'sd0, ydelta, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, 9'sd0, 9'sd0, 1'b1);
      if (k == 4) check("neg_edge4", 32'({YA, YB}), 32'(2'b01));
      if (k == 8) begin
        check("neg_edge8", 32'({YA, YB}), 32'(2'b11));
        check("neg_busy8", 32'(busy), 32'd0);
      end
    end
    check("neg_dec_count", 32'(dec_y), 32'h1FE);

    // Saturation: two +255 strobes leave exactly 255 steps pending.
    d0 = dec_x;
    cycle(1'b1, 9'sd255, 9'sd0, 1'b1);
    cycle(1'b1, 9'sd255, 9'sd0, 1'b1);
    guard = 0;
    while (busy && guard < 1200) begin
      cycle(1'b0, 9'sd0, 9'sd0, 1'b1);
      guard++;
    end
    check("sat_drained", 32'(busy), 32'd0);
    check("sat_edges", 32'(dec_x - d0), 32'd255);

    // Strobe of +1 exactly on the step cycle while pending is +1.
    d0 = dec_x;
    cycle(1'b1, 9'sd1, 9'sd0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      cycle((k == 4), (k == 4) ? 9'sd1 : 9'sd0, 9'sd0, 1'b1);
      if (k == 4) check("coin_busy4", 32'(busy), 32'd1);
      if (k == 7) check("coin_busy7", 32'(busy), 32'd1);
      if (k == 8) check("coin_busy8", 32'(busy), 32'd0);
    end
    check("coin_edges", 32'(dec_x - d0), 32'd2);

    // Reset mid-burst after 2 of 5 edges.
    cycle(1'b1, 9'sd5, 9'sd0, 1'b1);
    idle(9);
    check("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_out", 32'({XA, XB, YA, YB, busy}), 32'd0);
    model_reset();
    prev_x = 2'b00;
    prev_y = 2'b00;
    d0 = dec_x;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(40);
    check("mid_no_edges", 32'(dec_x - d0), 32'd0);

    // Random strobes, deltas and clock enables.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 7) == 0), 9'($urandom), 9'($urandom),
            ($urandom_range(0, 3) != 0));
    end
    guard = 0;
    while (model_busy() && guard < 2500) begin
      cycle(1'b0, 9'sd0, 9'sd0, 1'b1);
      guard++;
    end
    check("rand_drained", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
